// File: rtl/vga_timing_generator_if.sv
// Bundle of the VGA timing generator's data-side signals.
//
// Purpose: groups the pixel enable, mode/colour controls, frame-buffer read
// port (addresses out, pixel data back) and the VGA pin outputs so they can be
// passed as one port.
//
// Modports:
//   master - the timing generator: consumes enable/mode/colour/pixel data,
//            drives read addresses, syncs, colours and frame strobes.
//   slave  - the surrounding system (frame buffer + board pins), mirror image.
interface vga_timing_generator_if #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned CH_BITS  = 4
);

  localparam int unsigned HAW = $clog2(H_ACTIVE);
  localparam int unsigned VAW = $clog2(V_ACTIVE);

  // Controls
  logic                   i_en;
  logic [1:0]             i_mode;
  logic [3*CH_BITS-1:0]   i_color;

  // Frame-buffer read data
  logic [CH_BITS-1:0]     i_red;
  logic [CH_BITS-1:0]     i_green;
  logic [CH_BITS-1:0]     i_blue;

  // Frame-buffer read address
  logic [HAW-1:0]         o_horiz_addr;
  logic [VAW-1:0]         o_vert_addr;
  logic                   o_addr_valid;

  // VGA pins and frame status
  logic                   o_hs;
  logic                   o_vs;
  logic [CH_BITS-1:0]     o_red;
  logic [CH_BITS-1:0]     o_green;
  logic [CH_BITS-1:0]     o_blue;
  logic                   o_line_start;
  logic                   o_frame_start;
  logic                   o_vblank;

  modport master (
    input  i_en, i_mode, i_color, i_red, i_green, i_blue,
    output o_horiz_addr, o_vert_addr, o_addr_valid,
    output o_hs, o_vs, o_red, o_green, o_blue,
    output o_line_start, o_frame_start, o_vblank
  );

  modport slave (
    output i_en, i_mode, i_color, i_red, i_green, i_blue,
    input  o_horiz_addr, o_vert_addr, o_addr_valid,
    input  o_hs, o_vs, o_red, o_green, o_blue,
    input  o_line_start, o_frame_start, o_vblank
  );

endinterface

// File: rtl/vga_timing_generator.sv
// Parametrised VGA raster / timing engine.
//
// Purpose: walks a (h, v) raster over the programmed geometry, issues
// frame-buffer read addresses for the active area, and re-aligns the returned
// pixel data with sync/blank/strobe information through an
// OUTPUT_DELAY_COUNT-deep pipeline followed by one output register. Also
// provides colour-bar, grid and solid-colour test patterns.
//
// Ports:
//   i_clk   - system clock
//   i_arst  - asynchronous reset, active-high
//   vga_io  - vga_timing_generator_if.master:
//             i_en (pixel enable), i_mode, i_color, i_red/i_green/i_blue in;
//             o_horiz_addr/o_vert_addr/o_addr_valid read address out;
//             o_hs/o_vs, o_red/o_green/o_blue, o_line_start, o_frame_start,
//             o_vblank out.
//
// Latency: outputs for raster position (h, v) appear OUTPUT_DELAY_COUNT + 1
// enabled cycles after the counters held (h, v). Pixel data is sampled when
// the pipeline's last stage holds the position it was addressed for.
module vga_timing_generator #(
  parameter int unsigned H_ACTIVE           = 640,
  parameter int unsigned H_FP               = 16,
  parameter int unsigned H_SYNC             = 96,
  parameter int unsigned H_BP               = 48,
  parameter int unsigned V_ACTIVE           = 480,
  parameter int unsigned V_FP               = 10,
  parameter int unsigned V_SYNC             = 2,
  parameter int unsigned V_BP               = 33,
  parameter int unsigned HS_POL             = 0,
  parameter int unsigned VS_POL             = 0,
  parameter int unsigned CH_BITS            = 4,
  parameter int unsigned OUTPUT_DELAY_COUNT = 2
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  vga_timing_generator_if.master vga_io
);

  // ---------------------------------------------------------------------------
  // Geometry
  // ---------------------------------------------------------------------------
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned HCW = $clog2(H_TOTAL);
  localparam int unsigned VCW = $clog2(V_TOTAL);
  localparam int unsigned HAW = $clog2(H_ACTIVE);
  localparam int unsigned VAW = $clog2(V_ACTIVE);
  localparam int unsigned CW  = 3 * CH_BITS;

  localparam int unsigned HSyncBeg = H_ACTIVE + H_FP;
  localparam int unsigned HSyncEnd = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VSyncBeg = V_ACTIVE + V_FP;
  localparam int unsigned VSyncEnd = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [HCW-1:0] HLast = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] VLast = VCW'(V_TOTAL - 1);

  // Colour-bar boundaries: bar k starts at H_ACTIVE*k/8.
  localparam int unsigned Bar1 = H_ACTIVE * 1 / 8;
  localparam int unsigned Bar2 = H_ACTIVE * 2 / 8;
  localparam int unsigned Bar3 = H_ACTIVE * 3 / 8;
  localparam int unsigned Bar4 = H_ACTIVE * 4 / 8;
  localparam int unsigned Bar5 = H_ACTIVE * 5 / 8;
  localparam int unsigned Bar6 = H_ACTIVE * 6 / 8;
  localparam int unsigned Bar7 = H_ACTIVE * 7 / 8;

  localparam logic HsActive = (HS_POL != 0);
  localparam logic VsActive = (VS_POL != 0);

  localparam logic [1:0] ModeFb    = 2'd0;
  localparam logic [1:0] ModeBars  = 2'd1;
  localparam logic [1:0] ModeGrid  = 2'd2;
  localparam logic [1:0] ModeSolid = 2'd3;

  // One pipeline slot: everything the output stage needs about a position.
  typedef struct packed {
    logic          hsync;
    logic          vsync;
    logic          active;
    logic          vblank;
    logic          line_start;
    logic          frame_start;
    logic [1:0]    mode;
    logic [CW-1:0] pat;
  } stage_t;

  logic en;
  assign en = vga_io.i_en;

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [HCW-1:0] h_cnt_q, h_cnt_d;
  logic [VCW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (en) begin
      if (h_cnt_q == HLast) begin
        h_cnt_d = '0;
        if (v_cnt_q == VLast) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + VCW'(1);
        end
      end else begin
        h_cnt_d = h_cnt_q + HCW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Region decode (address stage)
  // ---------------------------------------------------------------------------
  // Widened copies so region limits that equal a power of two compare cleanly.
  logic [31:0] h_ext;
  logic [31:0] v_ext;
  logic        h_active, v_active, h_sync, v_sync, at_origin;

  assign h_ext     = 32'(h_cnt_q);
  assign v_ext     = 32'(v_cnt_q);
  assign h_active  = (h_ext < H_ACTIVE);
  assign v_active  = (v_ext < V_ACTIVE);
  assign h_sync    = (h_ext >= HSyncBeg) && (h_ext < HSyncEnd);
  assign v_sync    = (v_ext >= VSyncBeg) && (v_ext < VSyncEnd);
  assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

  assign vga_io.o_addr_valid = h_active & v_active;
  assign vga_io.o_horiz_addr = (h_active & v_active) ? HAW'(h_cnt_q) : '0;
  assign vga_io.o_vert_addr  = (h_active & v_active) ? VAW'(v_cnt_q) : '0;

  // ---------------------------------------------------------------------------
  // Mode latch
  // ---------------------------------------------------------------------------
  // The mode is captured as the raster leaves (0,0); pixel (0,0) itself already
  // uses the incoming mode so a whole frame is rendered in one mode.
  logic [1:0] mode_q, mode_d, cur_mode;

  assign cur_mode = at_origin ? vga_io.i_mode : mode_q;

  always_comb begin
    mode_d = mode_q;
    if (en && at_origin) begin
      mode_d = vga_io.i_mode;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      mode_q <= ModeFb;
    end else begin
      mode_q <= mode_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Test-pattern generation
  // ---------------------------------------------------------------------------
  logic [2:0]    bar_k;
  logic          grid_on;
  logic [CW-1:0] pat;

  always_comb begin
    bar_k = 3'd0;
    if (h_ext >= Bar7) begin
      bar_k = 3'd7;
    end else if (h_ext >= Bar6) begin
      bar_k = 3'd6;
    end else if (h_ext >= Bar5) begin
      bar_k = 3'd5;
    end else if (h_ext >= Bar4) begin
      bar_k = 3'd4;
    end else if (h_ext >= Bar3) begin
      bar_k = 3'd3;
    end else if (h_ext >= Bar2) begin
      bar_k = 3'd2;
    end else if (h_ext >= Bar1) begin
      bar_k = 3'd1;
    end
  end

  assign grid_on = (h_ext[3:0] == 4'd0) || (v_ext[3:0] == 4'd0);

  always_comb begin
    pat = '0;
    unique case (cur_mode)
      ModeBars:  pat = {{CH_BITS{bar_k[2]}}, {CH_BITS{bar_k[1]}}, {CH_BITS{bar_k[0]}}};
      ModeGrid:  pat = grid_on ? '1 : '0;
      ModeSolid: pat = vga_io.i_color;
      default:   pat = '0;  // frame-buffer mode takes its colour at the output stage
    endcase
  end

  // ---------------------------------------------------------------------------
  // Alignment pipeline
  // ---------------------------------------------------------------------------
  stage_t stage_in;
  stage_t pipe_q [OUTPUT_DELAY_COUNT];
  stage_t out_stage;

  always_comb begin
    stage_in             = '0;
    stage_in.hsync       = h_sync;
    stage_in.vsync       = v_sync;
    stage_in.active      = h_active & v_active;
    stage_in.vblank      = ~v_active;
    stage_in.line_start  = (h_cnt_q == '0);
    stage_in.frame_start = at_origin;
    stage_in.mode        = cur_mode;
    stage_in.pat         = pat;
  end

  // Reset contents ('0) decode as blank, sync-inactive, no strobes.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      for (int i = 0; i < OUTPUT_DELAY_COUNT; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (en) begin
      pipe_q[0] <= stage_in;
      for (int i = 1; i < OUTPUT_DELAY_COUNT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign out_stage = pipe_q[OUTPUT_DELAY_COUNT-1];

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic [CW-1:0] rgb_d, rgb_q;
  logic          hs_q, vs_q, vblank_q;
  logic          line_start_q, frame_start_q;

  always_comb begin
    rgb_d = '0;
    if (out_stage.active) begin
      if (out_stage.mode == ModeFb) begin
        rgb_d = {vga_io.i_red, vga_io.i_green, vga_io.i_blue};
      end else begin
        rgb_d = out_stage.pat;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      hs_q          <= ~HsActive;
      vs_q          <= ~VsActive;
      rgb_q         <= '0;
      vblank_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      // Strobes are re-evaluated every clock so they last exactly one cycle
      // even when the pixel itself is held across disabled cycles.
      line_start_q  <= en & out_stage.line_start;
      frame_start_q <= en & out_stage.frame_start;
      if (en) begin
        hs_q     <= out_stage.hsync ? HsActive : ~HsActive;
        vs_q     <= out_stage.vsync ? VsActive : ~VsActive;
        rgb_q    <= rgb_d;
        vblank_q <= out_stage.vblank;
      end
    end
  end

  assign vga_io.o_hs          = hs_q;
  assign vga_io.o_vs          = vs_q;
  assign vga_io.o_red         = rgb_q[3*CH_BITS-1:2*CH_BITS];
  assign vga_io.o_green       = rgb_q[2*CH_BITS-1:CH_BITS];
  assign vga_io.o_blue        = rgb_q[CH_BITS-1:0];
  assign vga_io.o_vblank      = vblank_q;
  assign vga_io.o_line_start  = line_start_q;
  assign vga_io.o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench for vga_timing_generator on a 16x8 raster
// (H 8/2/3/3, V 4/1/2/1, D=2, active-low syncs, 4-bit channels).
module tb_vga_timing_generator;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  vga_timing_generator_if #(.H_ACTIVE(8), .V_ACTIVE(4), .CH_BITS(4)) vga_if ();

  vga_timing_generator #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .CH_BITS(4), .OUTPUT_DELAY_COUNT(2)
  ) dut (
    .i_clk  (clk),
    .i_arst (arst),
    .vga_io (vga_if)
  );

  // Frame-buffer model: returns the address two enabled cycles later.
  logic [4:0] fb1, fb2;
  always @(posedge clk or posedge arst) begin
    if (arst) begin
      fb1 <= '0;
      fb2 <= '0;
    end else if (vga_if.i_en) begin
      fb1 <= {vga_if.o_horiz_addr, vga_if.o_vert_addr};
      fb2 <= fb1;
    end
  end
  assign vga_if.i_red   = {1'b0, fb2[4:2]};
  assign vga_if.i_green = {2'b00, fb2[1:0]};
  assign vga_if.i_blue  = 4'hA;

  typedef struct {
    int         h;
    int         v;
    logic       hs;
    logic       vs;
    logic       vb;
    logic       ls;
    logic       fs;
    logic [11:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Stimulus-side raster position and mode of the frame being addressed.
  int ph = 0;
  int pv = 0;
  int fmode = 0;

  function automatic exp_t rst_entry();
    exp_t e;
    e.h = -1; e.v = -1;
    e.hs = 1'b1; e.vs = 1'b1; e.vb = 1'b0; e.ls = 1'b0; e.fs = 1'b0; e.rgb = 12'h000;
    return e;
  endfunction

  function automatic exp_t model(int h, int v, int m, logic [11:0] col);
    exp_t        e;
    logic [31:0] hb;
    bit          act;
    hb  = h;
    act = (h < 8) && (v < 4);
    e.h  = h;
    e.v  = v;
    e.hs = !((h >= 10) && (h <= 12));
    e.vs = !((v >= 5) && (v <= 6));
    e.vb = (v >= 4);
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    if (!act) begin
      e.rgb = 12'h000;
    end else begin
      case (m)
        0:       e.rgb = {4'(h), 4'(v), 4'hA};
        1:       e.rgb = {hb[2] ? 4'hF : 4'h0, hb[1] ? 4'hF : 4'h0, hb[0] ? 4'hF : 4'h0};
        2:       e.rgb = ((h == 0) || (v == 0)) ? 12'hFFF : 12'h000;
        default: e.rgb = col;
      endcase
    end
    return e;
  endfunction

  task automatic compare(input exp_t e, input string tag);
    logic [11:0] rgb;
    rgb = {vga_if.o_red, vga_if.o_green, vga_if.o_blue};
    checks++;
    if (vga_if.o_hs !== e.hs || vga_if.o_vs !== e.vs || vga_if.o_vblank !== e.vb ||
        vga_if.o_line_start !== e.ls || vga_if.o_frame_start !== e.fs || rgb !== e.rgb) begin
      failures++;
      $display("FAIL %s(h=%0d,v=%0d) got hs=%b vs=%b vb=%b ls=%b fs=%b rgb=%h want hs=%b vs=%b vb=%b ls=%b fs=%b rgb=%h",
               tag, e.h, e.v, vga_if.o_hs, vga_if.o_vs, vga_if.o_vblank, vga_if.o_line_start,
               vga_if.o_frame_start, rgb, e.hs, e.vs, e.vb, e.ls, e.fs, e.rgb);
    end
  endtask

  task automatic check_addr(input logic [2:0] h, input logic [1:0] v, input logic valid,
                            input string tag);
    checks++;
    if (vga_if.o_horiz_addr !== h || vga_if.o_vert_addr !== v || vga_if.o_addr_valid !== valid) begin
      failures++;
      $display("FAIL %s got addr=(%0d,%0d) valid=%b want (%0d,%0d) valid=%b", tag,
               vga_if.o_horiz_addr, vga_if.o_vert_addr, vga_if.o_addr_valid, h, v, valid);
    end
  endtask

  // One clock of stimulus; on enabled clocks the expected output for the
  // current position is queued (it emerges three enabled edges later).
  task automatic tick(input bit en);
    vga_if.i_en = en;
    if (en) begin
      if (ph == 0 && pv == 0) fmode = int'(vga_if.i_mode);
      exp_q.push_back(model(ph, pv, fmode, vga_if.i_color));
      ph++;
      if (ph == 16) begin
        ph = 0;
        pv++;
        if (pv == 8) pv = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic restart();
    exp_q.delete();
    // Two enabled edges drain the cleared pipeline before (0,0) appears.
    exp_q.push_back(rst_entry());
    exp_q.push_back(rst_entry());
    ph = 0;
    pv = 0;
  endtask

  // Monitor: pops on every enabled edge, checks hold + quiet strobes otherwise.
  initial begin : monitor
    exp_t last, e;
    logic en_s, rst_s;
    last = rst_entry();
    forever begin
      @(posedge clk);
      en_s  = vga_if.i_en;
      rst_s = arst;
      #1;
      if (rst_s || arst) begin
        last = rst_entry();
      end else if (en_s) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow got empty queue want an entry");
        end else begin
          e = exp_q.pop_front();
          compare(e, "pix");
          last = e;
        end
      end else begin
        e    = last;
        e.ls = 1'b0;
        e.fs = 1'b0;
        compare(e, "hold");
      end
    end
  end

  initial begin : stimulus
    int guard;
    arst           = 1'b1;
    vga_if.i_en    = 1'b0;
    vga_if.i_mode  = 2'd0;
    vga_if.i_color = 12'h000;
    repeat (3) @(negedge clk);
    compare(rst_entry(), "reset_init");
    check_addr(3'd0, 2'd0, 1'b1, "reset_addr");
    arst = 1'b0;
    restart();

    // Frame-buffer mode, switch to bars during line 2 of the second frame.
    repeat (160) tick(1'b1);
    vga_if.i_mode = 2'd1;
    repeat (96 + 128) tick(1'b1);

    // Grid frame, then solid colour frame.
    vga_if.i_mode = 2'd2;
    repeat (128) tick(1'b1);
    vga_if.i_color = 12'h5A3;
    vga_if.i_mode  = 2'd3;
    repeat (128) tick(1'b1);

    // Enable one clock in four, crossing a frame boundary.
    vga_if.i_mode = 2'd0;
    for (int i = 0; i < 4 * 160; i++) tick((i % 4) == 3);

    // Reset asserted mid-frame at (6,2).
    guard = 0;
    while (!(ph == 6 && pv == 2) && guard < 200) begin
      tick(1'b1);
      guard++;
    end
    check_addr(3'(ph), 2'(pv), 1'b1, "addr_before_reset");
    vga_if.i_en = 1'b0;
    arst = 1'b1;
    exp_q.delete();
    #1;
    compare(rst_entry(), "reset_async");
    check_addr(3'd0, 2'd0, 1'b1, "reset_async_addr");
    @(negedge clk);
    @(negedge clk);
    compare(rst_entry(), "reset_held");
    arst = 1'b0;
    restart();
    repeat (140) tick(1'b1);

    vga_if.i_en = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Parametrised VGA raster/timing engine; next generation of the fixed 640x480 VGA output stage.
- Generates frame-buffer read addresses and H/V sync, then re-aligns the returned pixel data with sync/blank through a configurable-latency pipeline.
- Adds programmable porch/sync geometry, sync polarity, a pixel clock-enable (single clock domain) and built-in test-pattern modes.
- Sits between frame_buffers_datapath (read port) and the board VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, 1 = active-high hsync, 0 = active-low
- VS_POL, 0, 1 = active-high vsync, 0 = active-low
- CH_BITS, 4, bits per colour channel
- OUTPUT_DELAY_COUNT, 2, enabled cycles from address out to pixel data in (D, >=1)

Ports:
- i_clk  in  1  system clock
- i_arst  in  1  asynchronous reset, active-high
- i_en  in  1  pixel enable; all state advances only when 1
- i_mode  in  2  0=frame buffer, 1=colour bars, 2=grid, 3=solid i_color
- i_color  in  3*CH_BITS  solid colour {r,g,b} for mode 3
- i_red/i_green/i_blue  in  CH_BITS each  pixel data from frame buffer
- o_horiz_addr  out  $clog2(H_ACTIVE)  read column
- o_vert_addr  out  $clog2(V_ACTIVE)  read row
- o_addr_valid  out  1  address is inside active area
- o_hs, o_vs  out  1 each  sync outputs
- o_red/o_green/o_blue  out  CH_BITS each  colour to DAC
- o_line_start  out  1  pulse with first output pixel of each line
- o_frame_start  out  1  pulse with output pixel (0,0)
- o_vblank  out  1  output stage is in a non-active line

Behaviour:
- H_TOTAL = sum of H params; V_TOTAL likewise; counter widths $clog2(H_TOTAL), $clog2(V_TOTAL).
- h_cnt increments on i_en; wraps H_TOTAL-1 -> 0 and increments v_cnt; v_cnt wraps V_TOTAL-1 -> 0.
- Regions per axis: active [0,ACTIVE), FP, SYNC, BP, in that order.
- Address stage (combinational from counters): o_addr_valid = h_active & v_active; addresses = counters when valid, else 0.
- Sync/active/pattern/start flags enter a D-deep shift register (advances on i_en), then one output register; outputs for position (h,v) therefore appear D+1 enabled cycles after counters held (h,v). i_red/i_green/i_blue are sampled at stage D.
- Colour outside active area forced to 0 in every mode.
- Sync output = POL when in sync region, else ~POL.
- Mode is latched when counters reach (0,0); changes mid-frame take effect next frame.
- Colour bars: k = bar index 0..7, boundaries at H_ACTIVE*k/8 (localparams); r = all k[2], g = all k[1], b = all k[0].
- Grid: white (all ones) when h[3:0]==0 or v[3:0]==0, else 0.
- o_line_start/o_frame_start: single-cycle pulses, only on cycles with i_en=1; otherwise 0.
- i_en=0: counters, pipeline and outputs hold; strobes 0.
- Reset (any time, incl. mid-frame): counters (0,0), pipeline cleared to blank/sync-inactive, o_hs=~HS_POL, o_vs=~VS_POL, colours 0, strobes 0, o_vblank 0, latched mode 0. Restart from (0,0) after release.

Test Plan:
- Parameters H=8/2/3/3 (H_TOTAL=16), V=4/1/2/1 (V_TOTAL=8), D=2, i_en=1.
- Release reset -> o_frame_start and o_line_start high exactly at 3rd clock edge; o_hs=1, colours 0 before that.
- Steady state -> o_hs low for 3 clocks at offsets 10..12 after o_line_start; period 16; o_vs low for lines 5..6 (32 clocks); frame period 128; o_vblank high for lines 4..7.
- Mode 0, bench returns red=addr_h, green=addr_v after 2 cycles -> at line offset h in line v, o_red=h, o_green=v for h<8, v<4; 0 in blanking.
- i_mode 0->1 set at line 2 -> current frame unchanged; next frame pixel 5 gives r=F, g=0, b=F, pixel 0 is black.
- i_en high 1 of every 4 clocks -> line period 64 clocks; outputs constant between enables; strobes one clock wide.
- Assert i_arst at h=6,v=2 for 2 clocks -> outputs go to reset values immediately (async); after release, frame_start after 3 enabled cycles.
